// File: rtl/as2650_core.sv
// as2650_core: reduced Signetics 2650 CPU driving a multiplexed 8-bit address/data bus.
// Build option: define AS2650_DAR_EN to implement DAR (94-97); otherwise those opcodes are NOPs.
module as2650_core (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_dir,
  output logic       le_hi,
  output logic       le_lo,
  output logic       OEb,
  output logic       WEb,
  input  logic       sense,
  output logic       flag,
  output logic       carry,
  output logic       idc
);
  typedef enum logic [2:0] {S_IDLE1, S_IDLE2, S_AHI, S_ALO, S_READ, S_WRITE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, addr_reg, access_addr;
  logic [7:0]  hi_reg, ir_reg, wdata_reg, psl_reg, psl_next;
  logic [6:0]  psu_reg, psu_next;
  logic        hi_valid_reg, arg_reg, write_reg;
  logic [7:0]  regs_reg [4];
  logic [7:0]  op, imm, rv, r0v, add_a, add_b, wr_val;
  logic [8:0]  sum9;
  logic [1:0]  wr_idx;
  logic        wr_en, cin, rot_c, two_byte, do_exec, strr_exec, start_access;
  logic        unused_sense;

  // PSU bit 7 mirrors the pin; no instruction in this subset reads PSU back.
  assign unused_sense = sense;

  // During an operand read the opcode comes from ir_reg, otherwise straight off the bus.
  assign op  = arg_reg ? ir_reg : bus_in;
  assign imm = bus_in;
  assign rv  = regs_reg[op[1:0]];
  assign r0v = regs_reg[0];

  assign two_byte = (op[7:2] == 6'b000001) || (op[7:2] == 6'b100001) ||
                    (op[7:2] == 6'b110010) || (op[7:2] == 6'b011101);
  assign do_exec      = (state_reg == S_READ) && (arg_reg || !two_byte);
  assign strr_exec    = (state_reg == S_READ) && arg_reg && (ir_reg[7:2] == 6'b110010);
  assign start_access = (state_reg == S_IDLE2) || (state_reg == S_READ) || (state_reg == S_WRITE);

  assign cin   = psl_reg[3] & psl_reg[0];
  assign add_a = op[2] ? rv : r0v;
  assign add_b = op[2] ? imm : rv;
  assign sum9  = {1'b0, add_a} + {1'b0, add_b} + {8'b0, cin};

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = op[1:0];
    wr_val   = 8'h00;
    rot_c    = psl_reg[0];
    psl_next = psl_reg;
    psu_next = psu_reg;
    if (do_exec) begin
      casez (op)
        8'b0000_00??: begin wr_en = 1'b1; wr_idx = 2'd0; wr_val = rv; end
        8'b0000_01??: begin wr_en = 1'b1; wr_val = imm; end
        8'b1100_0000: ;
        8'b1100_00??: begin wr_en = 1'b1; wr_val = r0v; end
        8'b?101_00??: begin
          wr_en = 1'b1;
          if (psl_reg[3]) begin
            if (op[7]) {rot_c, wr_val} = {rv, psl_reg[0]};
            else       {wr_val, rot_c} = {psl_reg[0], rv};
            psl_next[0] = rot_c;
            psl_next[5] = wr_val[5];
          end else begin
            wr_val = op[7] ? {rv[6:0], rv[7]} : {rv[0], rv[7:1]};
          end
        end
        8'b1000_0???: begin
          wr_en       = 1'b1;
          wr_idx      = op[2] ? op[1:0] : 2'd0;
          wr_val      = sum9[7:0];
          psl_next[0] = sum9[8];
          // carry into bit 4 recovered from the sum and operand bits
          psl_next[5] = sum9[4] ^ add_a[4] ^ add_b[4];
          psl_next[2] = (add_a[7] == add_b[7]) && (sum9[7] != add_a[7]);
        end
`ifdef AS2650_DAR_EN
        8'b1001_01??: begin
          wr_en  = 1'b1;
          wr_val = {rv[7:4] + (psl_reg[0] ? 4'h0 : 4'hA), rv[3:0] + (psl_reg[5] ? 4'h0 : 4'hA)};
        end
`endif
        8'b0111_01??: begin
          case (op[1:0])
            2'd0:    psu_next = psu_reg & ~imm[6:0];
            2'd1:    psl_next = psl_reg & ~imm;
            2'd2:    psu_next = psu_reg | imm[6:0];
            default: psl_next = psl_reg | imm;
          endcase
        end
        default: ;
      endcase
      if (wr_en) psl_next[7:6] = (wr_val == 8'h00) ? 2'b00 : (wr_val[7] ? 2'b10 : 2'b01);
    end
  end

  // Next bus cycle: ADDR_HI is skipped while the latched high byte still matches.
  always_comb begin
    access_addr = pc_reg;
    if (state_reg == S_READ)
      access_addr = strr_exec ? pc_reg + 16'd1 + {{9{imm[6]}}, imm[6:0]} : pc_reg + 16'd1;
    case (state_reg)
      S_IDLE1: state_next = S_IDLE2;
      S_AHI:   state_next = S_ALO;
      S_ALO:   state_next = write_reg ? S_WRITE : S_READ;
      default: state_next = (!hi_valid_reg || access_addr[15:8] != hi_reg) ? S_AHI : S_ALO;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= S_IDLE1;
    else          state_reg <= state_next;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pc_reg       <= 16'h0000;
      addr_reg     <= 16'h0000;
      hi_reg       <= 8'h00;
      hi_valid_reg <= 1'b0;
      ir_reg       <= 8'h00;
      wdata_reg    <= 8'h00;
      arg_reg      <= 1'b0;
      write_reg    <= 1'b0;
      psl_reg      <= 8'h00;
      psu_reg      <= 7'h00;
      for (int i = 0; i < 4; i++) regs_reg[i] <= 8'h00;
    end else begin
      psl_reg <= psl_next;
      psu_reg <= psu_next;
      if (wr_en) regs_reg[wr_idx] <= wr_val;
      if (state_reg == S_AHI) begin
        hi_reg       <= addr_reg[15:8];
        hi_valid_reg <= 1'b1;
      end
      if (start_access) begin
        addr_reg  <= access_addr;
        write_reg <= strr_exec;
      end
      if (state_reg == S_READ) begin
        pc_reg  <= pc_reg + 16'd1;
        arg_reg <= !arg_reg && two_byte;
        if (!arg_reg) ir_reg <= bus_in;
      end
      if (strr_exec) wdata_reg <= rv;
    end
  end

  // Latch enables are gated with the clock so they fall mid-cycle.
  always_comb begin
    bus_out = 8'h00;
    bus_dir = 1'b0;
    le_hi   = 1'b0;
    le_lo   = 1'b0;
    OEb     = 1'b1;
    WEb     = 1'b1;
    case (state_reg)
      S_AHI:   begin bus_out = addr_reg[15:8]; le_hi = wb_clk_i; end
      S_ALO:   begin bus_out = addr_reg[7:0];  le_lo = wb_clk_i; end
      S_READ:  begin OEb = 1'b0; bus_dir = 1'b1; end
      S_WRITE: begin WEb = 1'b0; bus_out = wdata_reg; end
      default: ;
    endcase
  end

  assign flag  = psu_reg[6];
  assign carry = psl_reg[0];
  assign idc   = psl_reg[5];
endmodule

// File: tb/tb_as2650_core.sv
// Bench for as2650_core: program in a ROM model, expected store traffic queued, monitor compares writes.
module tb_as2650_core;
  logic       clk = 1'b0, rst = 1'b1, sense = 1'b0;
  logic [7:0] bus_in, bus_out;
  logic       bus_dir, le_hi, le_lo, OEb, WEb, flag, carry, idc;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        c, i, f;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  rom [0:1023];
  logic [7:0]  lat_hi = 8'h00, lat_lo = 8'h00;
  logic [15:0] mem_addr;
  int          checks = 0, failures = 0, hi_pulses = 0, wp = 0, n_exp = 0;

`ifdef AS2650_DAR_EN
  localparam bit DAR = 1'b1;
`else
  localparam bit DAR = 1'b0;
`endif

  as2650_core dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_dir(bus_dir),
    .le_hi(le_hi), .le_lo(le_lo), .OEb(OEb), .WEb(WEb), .sense(sense),
    .flag(flag), .carry(carry), .idc(idc)
  );

  always #5 clk = ~clk;

  assign mem_addr = {lat_hi, lat_lo};
  assign bus_in   = OEb ? 8'h00 : rom[mem_addr[9:0]];

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s#%0d got=%h expected=%h", name, id, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rom[wp[9:0]] = b;
    wp++;
  endtask

  task automatic p2(input logic [7:0] a, input logic [7:0] b);
    put(a);
    put(b);
  endtask

  // STRR r,disp at the current location; queue the write it must produce.
  task automatic st(input logic [1:0] r, input logic [7:0] disp, input logic [7:0] d,
                    input logic c, input logic i, input logic f);
    exp_t e;
    e.addr = 16'(wp + 2) + {{9{disp[6]}}, disp[6:0]};
    e.data = d;
    e.c    = c;
    e.i    = i;
    e.f    = f;
    e.id   = n_exp;
    n_exp++;
    exp_q.push_back(e);
    p2(8'hC8 | {6'b0, r}, disp);
  endtask

  task automatic add_case(input logic [7:0] a, input logic [7:0] b);
    p2(8'h04, a);
    p2(8'h05, b);
    p2(8'h84, 8'h66);
    put(8'h81);
  endtask

  task automatic build_program();
    logic [7:0] dar1, dar2, dar4;
    dar1 = DAR ? 8'h43 : 8'hA9;
    dar2 = DAR ? 8'h07 : 8'h0D;
    dar4 = DAR ? 8'h83 : 8'hE3;
    p2(8'h04, 8'h02); p2(8'h05, 8'h0A); p2(8'h06, 8'h32); p2(8'h07, 8'hC8);
    st(2'd0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    st(2'd1, 8'h80, 8'h0A, 1'b0, 1'b0, 1'b0);
    st(2'd2, 8'h7E, 8'h32, 1'b0, 1'b0, 1'b0);
    st(2'd3, 8'h00, 8'hC8, 1'b0, 1'b0, 1'b0);
    put(8'h50); st(2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    put(8'h50); st(2'd0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
    put(8'h50); st(2'd0, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0);
    put(8'hC1);
    put(8'hD1); st(2'd1, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
    put(8'hD1); st(2'd1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    put(8'hD1); st(2'd1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    p2(8'h77, 8'h08); p2(8'h07, 8'h21);
    put(8'h53); st(2'd3, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
    put(8'h53); st(2'd3, 8'h00, 8'h88, 1'b0, 1'b0, 1'b0);
    put(8'h03);
    put(8'hD0); st(2'd0, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
    put(8'hD0); st(2'd0, 8'h00, 8'h21, 1'b0, 1'b1, 1'b0);
    put(8'hD0); st(2'd0, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0);
    p2(8'h75, 8'h08);
    add_case(8'h12, 8'h31); put(8'h94); st(2'd0, 8'h00, dar1, 1'b0, 1'b0, 1'b0);
    add_case(8'h76, 8'h31); put(8'h94); st(2'd0, 8'h00, dar2, 1'b1, 1'b0, 1'b0);
    add_case(8'h76, 8'h35); put(8'h94); st(2'd0, 8'h00, 8'h11, 1'b1, 1'b1, 1'b0);
    add_case(8'h76, 8'h07); put(8'hC2); put(8'h96); put(8'h02);
    st(2'd0, 8'h00, dar4, 1'b0, 1'b1, 1'b0);
    st(2'd2, 8'h00, dar4, 1'b0, 1'b1, 1'b0);
    p2(8'h76, 8'h40); st(2'd0, 8'h00, dar4, 1'b0, 1'b1, 1'b1);
    p2(8'h74, 8'h40); p2(8'h77, 8'h01); st(2'd0, 8'h00, dar4, 1'b1, 1'b1, 1'b0);
    p2(8'h77, 8'h08); p2(8'h05, 8'h10); p2(8'h85, 8'h0F);
    st(2'd1, 8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    wp = 256;
    p2(8'h04, 8'h5A); st(2'd0, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0);
  endtask

  // Address latches and write monitor, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (le_hi) begin lat_hi = bus_out; hi_pulses++; end
    if (le_lo) lat_lo = bus_out;
    if (!rst && !OEb) chk("read_dir", 0, {15'b0, bus_dir}, 16'd1);
    if (!rst && !WEb) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write addr=%h data=%h expected no write", mem_addr, bus_out);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write %0d addr=%h data=%h C=%b IDC=%b F=%b", mon_e.id, mem_addr, bus_out, carry, idc, flag);
        chk("wr_addr", mon_e.id, mem_addr, mon_e.addr);
        chk("wr_data", mon_e.id, {8'b0, bus_out}, {8'b0, mon_e.data});
        chk("wr_carry", mon_e.id, {15'b0, carry}, {15'b0, mon_e.c});
        chk("wr_idc", mon_e.id, {15'b0, idc}, {15'b0, mon_e.i});
        chk("wr_flag", mon_e.id, {15'b0, flag}, {15'b0, mon_e.f});
        chk("wr_oeb", mon_e.id, {15'b0, OEb}, 16'd1);
        chk("wr_dir", mon_e.id, {15'b0, bus_dir}, 16'd0);
      end
    end
  end

  initial begin
    logic [7:0] a_hi, a_lo;
    for (int k = 0; k < 1024; k++) rom[k] = 8'hC0;
    build_program();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_out", 0, {8'b0, bus_out}, 16'h0000);
    chk("rst_le_hi", 0, {15'b0, le_hi}, 16'd0);
    chk("rst_le_lo", 0, {15'b0, le_lo}, 16'd0);
    chk("rst_oeb", 0, {15'b0, OEb}, 16'd1);
    chk("rst_web", 0, {15'b0, WEb}, 16'd1);
    chk("rst_dir", 0, {15'b0, bus_dir}, 16'd0);
    chk("rst_carry", 0, {15'b0, carry}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_le_hi", 0, {15'b0, le_hi}, 16'd0);
    chk("idle_oeb", 0, {15'b0, OEb}, 16'd1);
    @(posedge clk); #1;
    chk("ahi_le_hi", 0, {15'b0, le_hi}, 16'd1);
    chk("ahi_dir", 0, {15'b0, bus_dir}, 16'd0);
    a_hi = bus_out;
    @(posedge clk); #1;
    chk("alo_le_lo", 0, {15'b0, le_lo}, 16'd1);
    a_lo = bus_out;
    @(posedge clk); #1;
    chk("fetch_oeb", 0, {15'b0, OEb}, 16'd0);
    chk("fetch_addr", 0, {a_hi, a_lo}, 16'h0000);
    for (int k = 0; k < 20000 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout pending_writes=%0d expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #2;
    chk("addr_hi_cycles", 0, 16'(hi_pulses), 16'd2);
    chk("page_hi_byte", 0, {8'b0, lat_hi}, 16'h0001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
